// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and iterative-core modes for alu_muldiv
//
// Purpose: op-code constants (4-bit encoding kept from the single-cycle ALU),
//          top-level FSM state enum and iterative datapath mode enum.
// Ports:   none (package).
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

  // Ops that run through the multi-cycle core instead of the 1-cycle path.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - request/response bundle between the EX stage and alu_muldiv
//
// Purpose: groups the handshake, operand and result signals of alu_muldiv.
// Optional: ALU_OVF_EN adds overflow_o.
// Signals:
//   valid_i/ready_o   request handshake (accept on valid_i & ready_o)
//   ctrl_i            4-bit op code
//   src1_i/src2_i     operands A/B
//   flush_i           abort in-flight iterative op / block acceptance
//   valid_o           one-cycle result strobe
//   result_o/hi_o     LO result and HI register
//   zero_o            src1_i == src2_i of the op that produced valid_o
//   overflow_o        signed ADD/SUB overflow (ALU_OVF_EN only)
// Modports: master drives requests, slave is the ALU.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             flush_i;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;
`ifdef ALU_OVF_EN
  logic             overflow_o;
`endif

  modport master (
    output valid_i, ctrl_i, src1_i, src2_i, flush_i,
    input  ready_o, valid_o, result_o, hi_o, zero_o
`ifdef ALU_OVF_EN
    , input overflow_o
`endif
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i, flush_i,
    output ready_o, valid_o, result_o, hi_o, zero_o
`ifdef ALU_OVF_EN
    , output overflow_o
`endif
  );

endinterface

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - iterative unsigned shift-add multiplier / restoring divider
//
// Purpose: WIDTH-iteration MULTU/DIVU datapath; one iteration per clock.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_flush          abort the running operation
//   i_start          load operands and start (counter <= WIDTH-1)
//   i_mode           MODE_MUL or MODE_DIV
//   i_a, i_b         operands
//   o_done           high in the cycle whose closing edge performs the last iteration
//   o_hi, o_lo       value of HI/LO after the iteration of the current cycle
//                    (final product/remainder and quotient when o_done is high)
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_start,
  input  iter_mode_e       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // r_acc: product high half (mul) / partial remainder (div)
  // r_sh : multiplier shifting out, product low half shifting in (mul)
  //        dividend shifting out, quotient shifting in (div)
  // r_opd: multiplicand (mul) / divisor (div)
  logic             r_busy;
  iter_mode_e       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_rem_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_next_acc;
  logic [WIDTH-1:0] w_next_sh;

  // Shift-add: add multiplicand when the current multiplier bit is set, then
  // shift the 2*WIDTH+1 bit {carry, acc, sh} right by one.
  assign w_mul_sum = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opd} : '0);

  // Restoring division: bring the next dividend bit into the remainder and
  // keep the trial difference only when it does not go negative. The partial
  // remainder is always < divisor, so the difference fits in WIDTH bits.
  assign w_div_shift   = {r_acc, r_sh[WIDTH-1]};
  assign w_div_ge      = (w_div_shift >= {1'b0, r_opd});
  assign w_div_rem_sub = w_div_shift[WIDTH-1:0] - r_opd;

  always_comb begin
    w_next_acc = r_acc;
    w_next_sh  = r_sh;
    if (r_mode == MODE_MUL) begin
      w_next_acc = w_mul_sum[WIDTH:1];
      w_next_sh  = {w_mul_sum[0], r_sh[WIDTH-1:1]};
    end else begin
      w_next_acc = w_div_ge ? w_div_rem_sub : w_div_shift[WIDTH-1:0];
      w_next_sh  = {r_sh[WIDTH-2:0], w_div_ge};
    end
  end

  assign o_done = r_busy && (r_cnt == '0);
  assign o_hi   = w_next_acc;
  assign o_lo   = w_next_sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_mode <= MODE_MUL;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sh   <= '0;
      r_opd  <= '0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_mode <= i_mode;
      r_cnt  <= CNT_W'(WIDTH - 1);
      r_acc  <= '0;
      r_sh   <= (i_mode == MODE_MUL) ? i_b : i_a;
      r_opd  <= (i_mode == MODE_MUL) ? i_a : i_b;
    end else if (r_busy) begin
      r_acc <= w_next_acc;
      r_sh  <= w_next_sh;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - handshaked EX-stage ALU with iterative MULTU/DIVU
//
// Purpose: 1-cycle ADD/SUB/AND/OR/SLT plus WIDTH-cycle MULTU/DIVU writing HI/LO.
// Optional: define ALU_OVF_EN to add overflow_o (signed ADD/SUB overflow).
// Ports:
//   clk_i   clock (rising edge)
//   rst_i   synchronous active-high reset
//   bus     alu_muldiv_if.slave: valid_i/ready_o, ctrl_i, src1_i, src2_i,
//           flush_i, valid_o, result_o, hi_o, zero_o[, overflow_o]
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_muldiv_if.slave bus
);

  alu_state_e       r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_zero_pend;
`ifdef ALU_OVF_EN
  logic             r_ovf;
  logic             w_ovf;
`endif

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_single;
  logic             w_slt;
  logic             w_eq;
  logic             w_iter;
  logic             w_accept;
  logic             w_start;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;

  assign w_sum    = bus.src1_i + bus.src2_i;
  assign w_diff   = bus.src1_i - bus.src2_i;
  assign w_slt    = $signed(bus.src1_i) < $signed(bus.src2_i);
  assign w_eq     = (bus.src1_i == bus.src2_i);
  assign w_iter   = is_iter_op(bus.ctrl_i);
  // flush_i blocks acceptance even with valid_i high.
  assign w_accept = bus.valid_i && (r_state == IDLE) && !bus.flush_i;
  assign w_start  = w_accept && w_iter;

  always_comb begin
    w_single = '0;
    case (bus.ctrl_i)
      ALU_ADD: w_single = w_sum;
      ALU_SUB: w_single = w_diff;
      ALU_AND: w_single = bus.src1_i & bus.src2_i;
      ALU_OR:  w_single = bus.src1_i | bus.src2_i;
      ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_single = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    w_ovf = 1'b0;
    if (bus.ctrl_i == ALU_ADD) begin
      w_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
              (w_sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
    end else if (bus.ctrl_i == ALU_SUB) begin
      w_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
              (w_diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
    end
  end
`endif

  alu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (bus.flush_i),
    .i_start (w_start),
    .i_mode  ((bus.ctrl_i == ALU_DIVU) ? MODE_DIV : MODE_MUL),
    .i_a     (bus.src1_i),
    .i_b     (bus.src2_i),
    .o_done  (w_core_done),
    .o_hi    (w_core_hi),
    .o_lo    (w_core_lo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_zero_pend <= 1'b0;
`ifdef ALU_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_iter) begin
              // zero_o must track the op that strobes valid_o, so hold the
              // comparison until the iterative op completes.
              r_state     <= BUSY;
              r_zero_pend <= w_eq;
            end else begin
              r_valid  <= 1'b1;
              r_result <= w_single;
              r_zero   <= w_eq;
`ifdef ALU_OVF_EN
              r_ovf    <= w_ovf;
`endif
            end
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            r_state <= IDLE;
          end else if (w_core_done) begin
            r_state  <= IDLE;
            r_valid  <= 1'b1;
            r_result <= w_core_lo;
            r_hi     <= w_core_hi;
            r_zero   <= r_zero_pend;
`ifdef ALU_OVF_EN
            r_ovf    <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (r_state == IDLE);
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
  assign bus.hi_o     = r_hi;
  assign bus.zero_o   = r_zero;
`ifdef ALU_OVF_EN
  assign bus.overflow_o = r_ovf;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv (WIDTH=32 and WIDTH=8)
module tb_alu_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32)) b32 ();
  alu_muldiv_if #(.WIDTH(8))  b8 ();

  alu_muldiv #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  alu_muldiv #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] m_hi = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the op table evaluated with plain integer arithmetic.
  function automatic void model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, output logic [31:0] lo, output bit iter);
    logic [63:0] p;
    iter = 0;
    case (op)
      4'b0010: lo = a + b;
      4'b0110: lo = a - b;
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0111: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: begin p = 64'(a) * 64'(b); lo = p[31:0]; hi = p[63:32]; iter = 1; end
      4'b1010: begin
        iter = 1;
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: lo = 32'd0;
    endcase
  endfunction

  task automatic drive32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    b32.valid_i = 1'b1; b32.ctrl_i = op; b32.src1_i = a; b32.src2_i = b;
  endtask

  // Issue one iterative op on the 32-bit ALU and check latency and results.
  task automatic run_iter32(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi, input logic exp_z);
    int cyc;
    int lowcnt;
    drive32(op, a, b);
    tick();
    // A request during BUSY must be ignored.
    drive32(4'b0010, 32'd9, 32'd9);
    cyc = 1;
    lowcnt = 0;
    while (b32.valid_o !== 1'b1 && cyc < 60) begin
      if (b32.ready_o === 1'b0) lowcnt++;
      if (cyc == 20) b32.valid_i = 1'b0;
      tick();
      cyc++;
    end
    b32.valid_i = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'd33);
    chk({tag, " busy_cycles"}, 64'(lowcnt), 64'd32);
    chk({tag, " ready_at_valid"}, 64'(b32.ready_o), 64'd1);
    chk({tag, " lo"}, 64'(b32.result_o), 64'(exp_lo));
    chk({tag, " hi"}, 64'(b32.hi_o), 64'(exp_hi));
    chk({tag, " zero"}, 64'(b32.zero_o), 64'(exp_z));
    tick();
    chk({tag, " one_pulse"}, 64'(b32.valid_o), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, lo;
    logic [3:0]  op;
    bit          iter;
    int          cyc;
    logic [3:0]  op_tbl [10];
    op_tbl = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
               4'b1000, 4'b1010, 4'b0011, 4'b1111, 4'b1001};

    b32.valid_i = 0; b32.ctrl_i = 0; b32.src1_i = 0; b32.src2_i = 0; b32.flush_i = 0;
    b8.valid_i = 0;  b8.ctrl_i = 0;  b8.src1_i = 0;  b8.src2_i = 0;  b8.flush_i = 0;

    // Reset state
    tick(); tick();
    chk("rst valid", 64'(b32.valid_o), 64'd0);
    chk("rst result", 64'(b32.result_o), 64'd0);
    chk("rst hi", 64'(b32.hi_o), 64'd0);
    chk("rst zero", 64'(b32.zero_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("post-rst ready", 64'(b32.ready_o), 64'd1);

    // Back-to-back single-cycle ops
    drive32(4'b0010, 32'd7, 32'd5);
    tick();
    chk("add valid", 64'(b32.valid_o), 64'd1);
    chk("add result", 64'(b32.result_o), 64'd12);
    chk("add ready", 64'(b32.ready_o), 64'd1);
    drive32(4'b0110, 32'd3, 32'd5);
    tick();
    chk("sub valid", 64'(b32.valid_o), 64'd1);
    chk("sub result", 64'(b32.result_o), 64'hFFFF_FFFE);
    drive32(4'b0111, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt valid", 64'(b32.valid_o), 64'd1);
    chk("slt result", 64'(b32.result_o), 64'd1);
    chk("slt ready", 64'(b32.ready_o), 64'd1);
    b32.valid_i = 0;
    tick();
    chk("idle valid", 64'(b32.valid_o), 64'd0);

    // Iterative ops
    run_iter32("multu max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_iter32("divu 100/7", 4'b1010, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_iter32("divu 5/0", 4'b1010, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);

    // Flush during MULTU at cycle 10
    drive32(4'b1000, 32'd6, 32'd7);
    tick();
    b32.valid_i = 0;
    cyc = 1;
    while (cyc < 10) begin
      chk("flush no early valid", 64'(b32.valid_o), 64'd0);
      tick();
      cyc++;
    end
    b32.flush_i = 1'b1;
    tick();
    b32.flush_i = 1'b0;
    chk("flush valid", 64'(b32.valid_o), 64'd0);
    chk("flush ready", 64'(b32.ready_o), 64'd1);
    chk("flush hi kept", 64'(b32.hi_o), 64'd5);
    chk("flush result kept", 64'(b32.result_o), 64'hFFFF_FFFF);
    drive32(4'b0010, 32'd1, 32'd1);
    tick();
    b32.valid_i = 0;
    chk("post-flush add valid", 64'(b32.valid_o), 64'd1);
    chk("post-flush add", 64'(b32.result_o), 64'd2);
    chk("post-flush add zero", 64'(b32.zero_o), 64'd1);
    // Flush in IDLE blocks acceptance
    drive32(4'b0010, 32'd3, 32'd4);
    b32.flush_i = 1'b1;
    tick();
    b32.flush_i = 1'b0;
    b32.valid_i = 0;
    chk("idle flush no valid", 64'(b32.valid_o), 64'd0);
    chk("idle flush result kept", 64'(b32.result_o), 64'd2);
    tick();
    chk("idle flush no late valid", 64'(b32.valid_o), 64'd0);

    // Reset at cycle 5 of a DIVU, with an ignored request during BUSY
    drive32(4'b1010, 32'd1000, 32'd3);
    tick();
    drive32(4'b0010, 32'd2, 32'd2);
    for (int i = 1; i < 5; i++) begin
      chk("busy ignores valid_i", 64'(b32.valid_o), 64'd0);
      tick();
    end
    b32.valid_i = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst valid", 64'(b32.valid_o), 64'd0);
    chk("midrst result", 64'(b32.result_o), 64'd0);
    chk("midrst hi", 64'(b32.hi_o), 64'd0);
    chk("midrst zero", 64'(b32.zero_o), 64'd0);
    tick();
    chk("midrst ready", 64'(b32.ready_o), 64'd1);
    chk("midrst no valid", 64'(b32.valid_o), 64'd0);
    m_hi = '0;

    // Randomised ops against the reference model
    for (int n = 0; n < 30; n++) begin
      op = op_tbl[$urandom_range(9)];
      a  = $urandom;
      b  = ($urandom_range(3) == 0) ? a : 32'($urandom);
      if (op == 4'b1010 && $urandom_range(5) == 0) b = 32'd0;
      if ($urandom_range(3) == 0) a = a >> $urandom_range(31);
      model32(op, a, b, m_hi, lo, iter);
      if (iter) begin
        run_iter32($sformatf("rand%0d op%0h", n, op), op, a, b, lo, m_hi, a == b);
      end else begin
        drive32(op, a, b);
        tick();
        b32.valid_i = 0;
        chk($sformatf("rand%0d op%0h valid", n, op), 64'(b32.valid_o), 64'd1);
        chk($sformatf("rand%0d op%0h result", n, op), 64'(b32.result_o), 64'(lo));
        chk($sformatf("rand%0d op%0h hi", n, op), 64'(b32.hi_o), 64'(m_hi));
        chk($sformatf("rand%0d op%0h zero", n, op), 64'(b32.zero_o), 64'(a == b));
      end
    end

    // WIDTH=8 instance
    b8.valid_i = 1; b8.ctrl_i = 4'b0010; b8.src1_i = 8'h7F; b8.src2_i = 8'h01;
    tick();
    chk("w8 add result", 64'(b8.result_o), 64'h80);
`ifdef ALU_OVF_EN
    chk("w8 add ovf", 64'(b8.overflow_o), 64'd1);
`endif
    b8.ctrl_i = 4'b0110; b8.src1_i = 8'h80; b8.src2_i = 8'h01;
    tick();
    chk("w8 sub result", 64'(b8.result_o), 64'h7F);
`ifdef ALU_OVF_EN
    chk("w8 sub ovf", 64'(b8.overflow_o), 64'd1);
`endif
    b8.ctrl_i = 4'b0010; b8.src1_i = 8'h01; b8.src2_i = 8'h01;
    tick();
    chk("w8 add small", 64'(b8.result_o), 64'h02);
`ifdef ALU_OVF_EN
    chk("w8 add no ovf", 64'(b8.overflow_o), 64'd0);
`endif
    b8.ctrl_i = 4'b1000; b8.src1_i = 8'hFF; b8.src2_i = 8'hFF;
    tick();
    b8.valid_i = 0;
    cyc = 1;
    while (b8.valid_o !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("w8 multu latency", 64'(cyc), 64'd9);
    chk("w8 multu hi", 64'(b8.hi_o), 64'hFE);
    chk("w8 multu lo", 64'(b8.result_o), 64'h01);
`ifdef ALU_OVF_EN
    chk("w8 multu ovf", 64'(b8.overflow_o), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
